display_mode_ctrl: RTL and testbench

- Front-end controller for the alarm-clock display path. It decides what the seven-segment driver shows: current time, alarm time, or an edit buffer with the edited field blinking.
- It runs the user set-time and set-alarm sequences from debounced single-cycle button pulses.
- It commits edited values to the timekeeping and alarm registers with one-cycle load strobes.

---
 rtl/display_mode_ctrl_if.sv | 33 +++
 rtl/display_mode_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_display_mode_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_mode_ctrl_if.sv
// Button, time-source and display-side signals of the alarm-clock display controller.
// master drives buttons and time sources; slave is the controller itself.
interface display_mode_ctrl_if;
  logic       btn_mode;
  logic       btn_sel;
  logic       btn_inc;
  logic [7:0] time_min;
  logic [7:0] time_hr;
  logic [7:0] alarm_min;
  logic [7:0] alarm_hr;
  logic       alarm_ringing;
  logic [7:0] display_minutes;
  logic [7:0] display_hours;
  logic [3:0] digit_blank;
  logic [7:0] set_min;
  logic [7:0] set_hr;
  logic       load_time;
  logic       load_alarm;

  modport master (
    output btn_mode, btn_sel, btn_inc,
    output time_min, time_hr, alarm_min, alarm_hr, alarm_ringing,
    input  display_minutes, display_hours, digit_blank,
    input  set_min, set_hr, load_time, load_alarm
  );

  modport slave (
    input  btn_mode, btn_sel, btn_inc,
    input  time_min, time_hr, alarm_min, alarm_hr, alarm_ringing,
    output display_minutes, display_hours, digit_blank,
    output set_min, set_hr, load_time, load_alarm
  );
endinterface

// File: rtl/display_mode_ctrl.sv
// Alarm-clock display front end: view selection, set-time / set-alarm edit sequences,
// blinking of the edited field and one-cycle commit strobes.
module display_mode_ctrl #(
  parameter int BLINK_HALF   = 50_000_000,
  parameter int IDLE_TIMEOUT = 1_000_000_000
) (
  input  logic             clk,
  input  logic             rst,
  display_mode_ctrl_if.slave bus
);

  localparam int BLINK_W = (BLINK_HALF   > 1) ? $clog2(BLINK_HALF)   : 1;
  localparam int IDLE_W  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    SHOW_TIME,
    SHOW_ALARM,
    EDIT_T_HR,
    EDIT_T_MIN,
    EDIT_A_HR,
    EDIT_A_MIN
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         hr_q, hr_d;
  logic [7:0]         min_q, min_d;
  logic               load_time_q, load_time_d;
  logic               load_alarm_q, load_alarm_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;

  logic act_mode, act_sel, act_inc, any_btn;
  logic in_edit, timeout, blink_clr;
  logic [7:0] disp_hr, disp_min;
  logic [3:0] blank;

  // Captured values that are not valid in-range BCD are replaced by 00.
  function automatic logic [7:0] sanitize_hr(input logic [7:0] b);
    if (b[7:4] <= 4'd2 && b[3:0] <= 4'd9 && b <= 8'h23) return b;
    return 8'h00;
  endfunction

  function automatic logic [7:0] sanitize_min(input logic [7:0] b);
    if (b[7:4] <= 4'd5 && b[3:0] <= 4'd9) return b;
    return 8'h00;
  endfunction

  function automatic logic [7:0] inc_hr(input logic [7:0] b);
    if (b == 8'h23)       return 8'h00;
    if (b[3:0] == 4'd9)   return {b[7:4] + 4'd1, 4'h0};
    return {b[7:4], b[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_min(input logic [7:0] b);
    if (b == 8'h59)       return 8'h00;
    if (b[3:0] == 4'd9)   return {b[7:4] + 4'd1, 4'h0};
    return {b[7:4], b[3:0] + 4'd1};
  endfunction

  // Only the highest-priority pulse acts: mode > sel > inc.
  assign act_mode = bus.btn_mode;
  assign act_sel  = bus.btn_sel & ~bus.btn_mode;
  assign act_inc  = bus.btn_inc & ~bus.btn_mode & ~bus.btn_sel;
  assign any_btn  = bus.btn_mode | bus.btn_sel | bus.btn_inc;

  assign in_edit = (state_q == EDIT_T_HR) || (state_q == EDIT_T_MIN) ||
                   (state_q == EDIT_A_HR) || (state_q == EDIT_A_MIN);
  assign timeout = in_edit && !any_btn && (idle_q == IDLE_W'(IDLE_TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    hr_d         = hr_q;
    min_d        = min_q;
    load_time_d  = 1'b0;
    load_alarm_d = 1'b0;
    blink_clr    = 1'b0;

    case (state_q)
      SHOW_TIME: begin
        if (act_mode) begin
          state_d = SHOW_ALARM;
        end else if (act_sel) begin
          state_d = EDIT_T_HR;
          hr_d    = sanitize_hr(bus.time_hr);
          min_d   = sanitize_min(bus.time_min);
        end
      end
      SHOW_ALARM: begin
        if (act_mode) begin
          state_d = SHOW_TIME;
        end else if (act_sel) begin
          state_d = EDIT_A_HR;
          hr_d    = sanitize_hr(bus.alarm_hr);
          min_d   = sanitize_min(bus.alarm_min);
        end
      end
      EDIT_T_HR, EDIT_A_HR: begin
        if (act_mode || timeout) begin
          state_d = (state_q == EDIT_T_HR) ? SHOW_TIME : SHOW_ALARM;
        end else if (act_sel) begin
          state_d   = (state_q == EDIT_T_HR) ? EDIT_T_MIN : EDIT_A_MIN;
          blink_clr = 1'b1;
        end else if (act_inc) begin
          hr_d      = inc_hr(hr_q);
          blink_clr = 1'b1;
        end
      end
      EDIT_T_MIN, EDIT_A_MIN: begin
        if (act_mode || timeout) begin
          state_d = (state_q == EDIT_T_MIN) ? SHOW_TIME : SHOW_ALARM;
        end else if (act_sel) begin
          // Buffer is left untouched so set_hr/set_min are stable under the strobe.
          state_d      = (state_q == EDIT_T_MIN) ? SHOW_TIME : SHOW_ALARM;
          load_time_d  = (state_q == EDIT_T_MIN);
          load_alarm_d = (state_q == EDIT_A_MIN);
          blink_clr    = 1'b1;
        end else if (act_inc) begin
          min_d     = inc_min(min_q);
          blink_clr = 1'b1;
        end
      end
      default: state_d = SHOW_TIME;
    endcase
  end

  always_comb begin
    if (!in_edit || any_btn || timeout) idle_d = '0;
    else                                idle_d = idle_q + IDLE_W'(1);
  end

  // Edit activity restarts the blink so the new value is seen at once.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    blink_ph_d  = blink_ph_q;
    if (blink_clr) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SHOW_TIME;
      hr_q         <= 8'h00;
      min_q        <= 8'h00;
      load_time_q  <= 1'b0;
      load_alarm_q <= 1'b0;
      blink_cnt_q  <= '0;
      blink_ph_q   <= 1'b0;
      idle_q       <= '0;
    end else begin
      state_q      <= state_d;
      hr_q         <= hr_d;
      min_q        <= min_d;
      load_time_q  <= load_time_d;
      load_alarm_q <= load_alarm_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_ph_q   <= blink_ph_d;
      idle_q       <= idle_d;
    end
  end

  always_comb begin
    disp_hr  = hr_q;
    disp_min = min_q;
    blank    = 4'b0000;
    case (state_q)
      SHOW_TIME: begin
        disp_hr  = bus.time_hr;
        disp_min = bus.time_min;
        if (bus.alarm_ringing && blink_ph_q) blank = 4'b1111;
      end
      SHOW_ALARM: begin
        disp_hr  = bus.alarm_hr;
        disp_min = bus.alarm_min;
      end
      EDIT_T_HR, EDIT_A_HR: begin
        if (blink_ph_q) blank = 4'b1100;
      end
      EDIT_T_MIN, EDIT_A_MIN: begin
        if (blink_ph_q) blank = 4'b0011;
      end
      default: blank = 4'b0000;
    endcase
  end

  assign bus.display_hours   = disp_hr;
  assign bus.display_minutes = disp_min;
  assign bus.digit_blank     = blank;
  assign bus.set_hr          = hr_q;
  assign bus.set_min         = min_q;
  assign bus.load_time       = load_time_q;
  assign bus.load_alarm      = load_alarm_q;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Bench for display_mode_ctrl: directed scenarios plus randomized button traffic,
// all checked against a decimal-arithmetic model of the user-visible behaviour.
module tb_display_mode_ctrl;
  localparam int BH = 4;
  localparam int IT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail  = 0;

  display_mode_ctrl_if bus();

  display_mode_ctrl #(.BLINK_HALF(BH), .IDLE_TIMEOUT(IT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: view/edit flags, decimal buffer, and edge timestamps for blink/idle.
  bit m_edit, m_field_min, m_tgt_alarm, m_view_alarm, m_load_t, m_load_a;
  int m_hr, m_min, m_n, m_clr, m_last;

  function automatic int bcd2int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int capture(input logic [7:0] b, input int maxv);
    if (b[7:4] <= 4'd9 && b[3:0] <= 4'd9 && bcd2int(b) <= maxv) return bcd2int(b);
    return 0;
  endfunction

  task automatic model_reset();
    m_edit = 0; m_field_min = 0; m_tgt_alarm = 0; m_view_alarm = 0;
    m_load_t = 0; m_load_a = 0; m_hr = 0; m_min = 0;
    m_n = 0; m_clr = 0; m_last = 0;
  endtask

  task automatic model_step();
    m_n++;
    m_load_t = 0;
    m_load_a = 0;
    if (bus.btn_mode) begin
      if (m_edit) begin m_edit = 0; m_view_alarm = m_tgt_alarm; end
      else m_view_alarm = !m_view_alarm;
      m_last = m_n;
    end else if (bus.btn_sel) begin
      if (!m_edit) begin
        m_edit = 1; m_field_min = 0; m_tgt_alarm = m_view_alarm;
        m_hr  = capture(m_view_alarm ? bus.alarm_hr  : bus.time_hr, 23);
        m_min = capture(m_view_alarm ? bus.alarm_min : bus.time_min, 59);
      end else if (!m_field_min) begin
        m_field_min = 1; m_clr = m_n;
      end else begin
        m_load_t = !m_tgt_alarm; m_load_a = m_tgt_alarm;
        m_edit = 0; m_view_alarm = m_tgt_alarm; m_clr = m_n;
      end
      m_last = m_n;
    end else if (bus.btn_inc) begin
      if (m_edit) begin
        if (m_field_min) m_min = (m_min + 1) % 60;
        else             m_hr  = (m_hr + 1) % 24;
        m_clr = m_n;
      end
      m_last = m_n;
    end else if (m_edit && (m_n - m_last == IT)) begin
      m_edit = 0; m_view_alarm = m_tgt_alarm;
    end
  endtask

  function automatic logic [7:0] exp_disp_hr();
    if (m_edit) return int2bcd(m_hr);
    return m_view_alarm ? bus.alarm_hr : bus.time_hr;
  endfunction

  function automatic logic [7:0] exp_disp_min();
    if (m_edit) return int2bcd(m_min);
    return m_view_alarm ? bus.alarm_min : bus.time_min;
  endfunction

  function automatic logic [3:0] exp_blank();
    bit ph;
    ph = (((m_n - m_clr) / BH) % 2) == 1;
    if (m_edit && ph) return m_field_min ? 4'b0011 : 4'b1100;
    if (!m_edit && !m_view_alarm && bus.alarm_ringing && ph) return 4'b1111;
    return 4'b0000;
  endfunction

  task automatic tick(input bit m, input bit s, input bit i);
    bus.btn_mode = m; bus.btn_sel = s; bus.btn_inc = i;
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    bus.btn_mode = 0; bus.btn_sel = 0; bus.btn_inc = 0;
  endtask

  task automatic set_inputs(input logic [7:0] th, input logic [7:0] tm,
                            input logic [7:0] ah, input logic [7:0] am);
    bus.time_hr = th; bus.time_min = tm; bus.alarm_hr = ah; bus.alarm_min = am;
  endtask

  task automatic test_reset();
    rst = 1;
    bus.btn_mode = 0; bus.btn_sel = 0; bus.btn_inc = 0; bus.alarm_ringing = 0;
    set_inputs(8'h12, 8'h34, 8'h06, 8'h30);
    model_reset();
    repeat (2) tick(0, 0, 0);
    n_tests++; if (bus.display_hours !== 8'h12) begin n_fail++; $display("FAIL reset_disp_hr: got %h want 12", bus.display_hours); end
    n_tests++; if (bus.display_minutes !== 8'h34) begin n_fail++; $display("FAIL reset_disp_min: got %h want 34", bus.display_minutes); end
    n_tests++; if (bus.digit_blank !== 4'b0000) begin n_fail++; $display("FAIL reset_blank: got %b want 0000", bus.digit_blank); end
    n_tests++; if (bus.load_time !== 1'b0 || bus.load_alarm !== 1'b0) begin n_fail++; $display("FAIL reset_loads: got %b%b want 00", bus.load_time, bus.load_alarm); end
    n_tests++; if (bus.set_hr !== 8'h00 || bus.set_min !== 8'h00) begin n_fail++; $display("FAIL reset_buffer: got %h:%h want 00:00", bus.set_hr, bus.set_min); end
    rst = 0;
  endtask

  task automatic test_set_time();
    logic [7:0] exp_h [3];
    exp_h[0] = 8'h23; exp_h[1] = 8'h00; exp_h[2] = 8'h01;
    set_inputs(8'h22, 8'h59, 8'h06, 8'h30);
    tick(0, 1, 0);
    n_tests++; if (bus.display_hours !== 8'h22 || bus.display_minutes !== 8'h59) begin n_fail++; $display("FAIL settime_capture: got %h:%h want 22:59", bus.display_hours, bus.display_minutes); end
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 1);
      n_tests++; if (bus.display_hours !== exp_h[k]) begin n_fail++; $display("FAIL settime_inc_hr%0d: got %h want %h", k, bus.display_hours, exp_h[k]); end
    end
    tick(0, 1, 0);
    tick(0, 0, 1);
    n_tests++; if (bus.display_minutes !== 8'h00) begin n_fail++; $display("FAIL settime_min_wrap: got %h want 00", bus.display_minutes); end
    n_tests++; if (bus.load_time !== 1'b0) begin n_fail++; $display("FAIL settime_early_load: got %b want 0", bus.load_time); end
    tick(0, 1, 0);
    n_tests++; if (bus.load_time !== 1'b1) begin n_fail++; $display("FAIL settime_load: got %b want 1", bus.load_time); end
    n_tests++; if (bus.set_hr !== 8'h01 || bus.set_min !== 8'h00) begin n_fail++; $display("FAIL settime_setval: got %h:%h want 01:00", bus.set_hr, bus.set_min); end
    n_tests++; if (bus.display_hours !== 8'h22) begin n_fail++; $display("FAIL settime_back_show: got %h want 22", bus.display_hours); end
    tick(0, 0, 0);
    n_tests++; if (bus.load_time !== 1'b0 || bus.load_alarm !== 1'b0) begin n_fail++; $display("FAIL settime_strobe_len: got %b%b want 00", bus.load_time, bus.load_alarm); end
  endtask

  task automatic test_blink();
    logic [3:0] e;
    set_inputs(8'h12, 8'h34, 8'h06, 8'h30);
    tick(0, 1, 0);
    tick(0, 1, 0);
    for (int k = 0; k < 14; k++) begin
      if (k != 0) tick(0, 0, 0);
      e = (((k / 4) % 2) == 1) ? 4'b0011 : 4'b0000;
      n_tests++; if (bus.digit_blank !== e) begin n_fail++; $display("FAIL blink_min_k%0d: got %b want %b", k, bus.digit_blank, e); end
    end
    tick(0, 0, 1);
    n_tests++; if (bus.display_minutes !== 8'h35) begin n_fail++; $display("FAIL blink_inc_val: got %h want 35", bus.display_minutes); end
    for (int j = 0; j < 6; j++) begin
      if (j != 0) tick(0, 0, 0);
      e = (j < 4) ? 4'b0000 : 4'b0011;
      n_tests++; if (bus.digit_blank !== e) begin n_fail++; $display("FAIL blink_after_inc_j%0d: got %b want %b", j, bus.digit_blank, e); end
    end
    tick(1, 0, 0);
  endtask

  task automatic test_alarm_abort();
    set_inputs(8'h12, 8'h34, 8'h06, 8'h30);
    tick(1, 0, 0);
    n_tests++; if (bus.display_hours !== 8'h06 || bus.display_minutes !== 8'h30) begin n_fail++; $display("FAIL alarm_view: got %h:%h want 06:30", bus.display_hours, bus.display_minutes); end
    tick(0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      tick(0, 0, 1);
      n_tests++; if (bus.load_alarm !== 1'b0) begin n_fail++; $display("FAIL alarm_no_load_%0d: got %b want 0", k, bus.load_alarm); end
    end
    n_tests++; if (bus.display_hours !== 8'h08 || bus.display_minutes !== 8'h30) begin n_fail++; $display("FAIL alarm_edit_disp: got %h:%h want 08:30", bus.display_hours, bus.display_minutes); end
    tick(1, 0, 0);
    n_tests++; if (bus.display_hours !== 8'h06 || bus.display_minutes !== 8'h30) begin n_fail++; $display("FAIL alarm_abort_disp: got %h:%h want 06:30", bus.display_hours, bus.display_minutes); end
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (bus.load_alarm !== 1'b0 || bus.load_time !== 1'b0) begin n_fail++; $display("FAIL alarm_abort_load_%0d: got %b%b want 00", k, bus.load_alarm, bus.load_time); end
      tick(0, 0, 0);
    end
    n_tests++; if (bus.display_hours !== 8'h06) begin n_fail++; $display("FAIL alarm_stays_view: got %h want 06", bus.display_hours); end
    tick(1, 0, 0);
  endtask

  task automatic test_idle_timeout();
    set_inputs(8'h12, 8'h34, 8'h06, 8'h30);
    tick(0, 1, 0);
    set_inputs(8'h05, 8'h05, 8'h06, 8'h30);
    for (int c = 1; c <= 64; c++) begin
      tick(0, 0, 0);
      n_tests++; if (bus.load_time !== 1'b0) begin n_fail++; $display("FAIL idle_load_c%0d: got %b want 0", c, bus.load_time); end
      if (c == 63) begin
        n_tests++; if (bus.display_hours !== 8'h12) begin n_fail++; $display("FAIL idle_still_edit: got %h want 12", bus.display_hours); end
      end
    end
    n_tests++; if (bus.display_hours !== 8'h05) begin n_fail++; $display("FAIL idle_abort: got %h want 05", bus.display_hours); end
    set_inputs(8'h12, 8'h34, 8'h06, 8'h30);
    tick(0, 1, 0);
    set_inputs(8'h05, 8'h05, 8'h06, 8'h30);
    for (int c = 1; c <= 124; c++) begin
      tick(0, 0, c == 60);
      if (c == 64 || c == 123) begin
        n_tests++; if (bus.display_hours !== 8'h13) begin n_fail++; $display("FAIL idle_restart_c%0d: got %h want 13", c, bus.display_hours); end
      end
    end
    n_tests++; if (bus.display_hours !== 8'h05 || bus.load_time !== 1'b0) begin n_fail++; $display("FAIL idle_restart_abort: got %h/%b want 05/0", bus.display_hours, bus.load_time); end
  endtask

  task automatic test_priority();
    set_inputs(8'h12, 8'h34, 8'h06, 8'h30);
    tick(1, 1, 0);
    n_tests++; if (bus.display_hours !== 8'h06) begin n_fail++; $display("FAIL prio_mode_wins: got %h want 06", bus.display_hours); end
    n_tests++; if (bus.set_hr !== 8'h13 || bus.set_min !== 8'h34) begin n_fail++; $display("FAIL prio_no_capture: got %h:%h want 13:34", bus.set_hr, bus.set_min); end
    tick(1, 0, 0);
    set_inputs(8'h3A, 8'h15, 8'h06, 8'h30);
    tick(0, 1, 0);
    n_tests++; if (bus.set_hr !== 8'h00 || bus.set_min !== 8'h15) begin n_fail++; $display("FAIL capture_bad_hr: got %h:%h want 00:15", bus.set_hr, bus.set_min); end
    tick(0, 1, 1);
    n_tests++; if (bus.set_hr !== 8'h00 || bus.set_min !== 8'h15) begin n_fail++; $display("FAIL prio_sel_over_inc: got %h:%h want 00:15", bus.set_hr, bus.set_min); end
    tick(1, 0, 0);
    set_inputs(8'h23, 8'h60, 8'h06, 8'h30);
    tick(0, 1, 0);
    n_tests++; if (bus.set_hr !== 8'h23 || bus.set_min !== 8'h00) begin n_fail++; $display("FAIL capture_bad_min: got %h:%h want 23:00", bus.set_hr, bus.set_min); end
    tick(1, 0, 0);
  endtask

  task automatic test_random();
    int r;
    bit m, s, i;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 1) == 0)
          set_inputs(int2bcd($urandom_range(0, 23)), int2bcd($urandom_range(0, 59)),
                     int2bcd($urandom_range(0, 23)), int2bcd($urandom_range(0, 59)));
        else
          set_inputs(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 29) == 0) bus.alarm_ringing = !bus.alarm_ringing;
      m = 0; s = 0; i = 0;
      if ((cyc % 200) < 110) begin
        r = $urandom_range(0, 99);
        m = (r < 4) || (r == 99);
        s = (r >= 4 && r < 12) || (r >= 98);
        i = (r >= 12 && r < 24) || (r == 97) || (r == 99);
      end
      if (cyc == 1500) begin
        #2 rst = 1;
        model_reset();
        #1;
        n_tests++; if (bus.set_hr !== 8'h00 || bus.set_min !== 8'h00 || bus.load_time !== 1'b0) begin n_fail++; $display("FAIL rand_async_reset: got %h:%h/%b want 00:00/0", bus.set_hr, bus.set_min, bus.load_time); end
        tick(0, 0, 0);
        rst = 0;
      end
      tick(m, s, i);
      n_tests++; if (bus.display_hours !== exp_disp_hr()) begin n_fail++; if (n_fail < 20) $display("FAIL rand_disp_hr cyc%0d: got %h want %h", cyc, bus.display_hours, exp_disp_hr()); end
      n_tests++; if (bus.display_minutes !== exp_disp_min()) begin n_fail++; if (n_fail < 20) $display("FAIL rand_disp_min cyc%0d: got %h want %h", cyc, bus.display_minutes, exp_disp_min()); end
      n_tests++; if (bus.digit_blank !== exp_blank()) begin n_fail++; if (n_fail < 20) $display("FAIL rand_blank cyc%0d: got %b want %b", cyc, bus.digit_blank, exp_blank()); end
      n_tests++; if (bus.set_hr !== int2bcd(m_hr) || bus.set_min !== int2bcd(m_min)) begin n_fail++; if (n_fail < 20) $display("FAIL rand_set cyc%0d: got %h:%h want %h:%h", cyc, bus.set_hr, bus.set_min, int2bcd(m_hr), int2bcd(m_min)); end
      n_tests++; if (bus.load_time !== m_load_t || bus.load_alarm !== m_load_a) begin n_fail++; if (n_fail < 20) $display("FAIL rand_loads cyc%0d: got %b%b want %b%b", cyc, bus.load_time, bus.load_alarm, m_load_t, m_load_a); end
    end
  endtask

  initial begin
    test_reset();
    test_set_time();
    test_blink();
    test_alarm_abort();
    test_idle_timeout();
    test_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
